// File: rtl/gol_seed_loader.sv
// gol_seed_loader: row-serial seed deserializer for the Game of Life core.
// Collects ROWS rows of COLS cells (row r lands at seed[r*COLS +: COLS]),
// checks the framing against row_last, and holds the finished board behind
// a seed_valid/seed_ack handshake. abort drops a partial frame or held seed.
// Optional build macro: SEED_NONZERO_CHECK_EN -- when defined, a correctly
// framed board that completes as all zeros is rejected with frame_err
// instead of being presented.
module gol_seed_loader #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [COLS-1:0]        row_data,
    input  logic                   row_valid,
    input  logic                   row_last,
    output logic                   row_ready,
    input  logic                   abort,
    output logic [ROWS*COLS-1:0]   seed,
    output logic                   seed_valid,
    input  logic                   seed_ack,
    output logic                   frame_err,
    output logic [CNT_W-1:0]       frames_loaded
);

    localparam int IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     row_idx_q, row_idx_d;
    logic                 frame_err_q, frame_err_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ROWS*COLS-1:0] seed_q, seed_d;
    logic [ROWS-1:0]      row_we;

    logic accept;
    logic is_last_idx;
    logic frame_bad;
    logic row_ok;
    logic zero_reject;

    // abort wins over any beat, so a beat is only taken when abort is low
    assign accept      = row_valid && (state_q == ST_COLLECT) && !abort;
    assign is_last_idx = (row_idx_q == LAST_IDX);
    // row_last must be set exactly on the final row index
    assign frame_bad   = accept && (row_last != is_last_idx);
    assign row_ok      = accept && !frame_bad;

    // Per-row write enable and next-seed mux; untouched rows keep stale bits
    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
            assign row_we[gi] = row_ok && (row_idx_q == IDX_W'(gi));
            assign seed_d[gi*COLS +: COLS] = row_we[gi] ? row_data
                                                        : seed_q[gi*COLS +: COLS];
        end
    endgenerate

`ifdef SEED_NONZERO_CHECK_EN
    // The completed board includes the final row being written this cycle
    assign zero_reject = row_ok && is_last_idx && (seed_d == '0);
`else
    assign zero_reject = 1'b0;
`endif

    // Next-state logic: abort first, then row collection or handoff
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        frame_err_d = 1'b0;
        cnt_d       = cnt_q;
        if (abort) begin
            state_d   = ST_COLLECT;
            row_idx_d = '0;
        end else if (state_q == ST_COLLECT) begin
            if (frame_bad || zero_reject) begin
                row_idx_d   = '0;
                frame_err_d = 1'b1;
            end else if (row_ok) begin
                if (is_last_idx) begin
                    state_d   = ST_HOLD;
                    row_idx_d = '0;
                end else begin
                    row_idx_d = row_idx_q + IDX_W'(1);
                end
            end
        end else if (seed_ack) begin
            state_d = ST_COLLECT;
            cnt_d   = cnt_q + CNT_W'(1);
        end
    end

    // Control and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            row_idx_q   <= '0;
            frame_err_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            frame_err_q <= frame_err_d;
            cnt_q       <= cnt_d;
        end
    end

    // Seed storage; rows are only written while collecting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seed_q <= '0;
        end else begin
            seed_q <= seed_d;
        end
    end

    assign row_ready     = (state_q == ST_COLLECT);
    assign seed_valid    = (state_q == ST_HOLD);
    assign seed          = seed_q;
    assign frame_err     = frame_err_q;
    assign frames_loaded = cnt_q;

endmodule

// File: tb/tb_gol_seed_loader.sv
// Bench for gol_seed_loader: a vector table for the basic flow, hand-written
// corner sequences, then random traffic against a frame-level model.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_gol_seed_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  row_data;
    logic        row_valid, row_last, abort, seed_ack;
    logic        row_ready, seed_valid, frame_err;
    logic [63:0] seed;
    logic [15:0] frames_loaded;
    logic        row_ready2, seed_valid2, frame_err2;
    logic [63:0] seed2;
    logic [1:0]  frames_loaded2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gol_seed_loader #(.ROWS(8), .COLS(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .row_data(row_data), .row_valid(row_valid),
        .row_last(row_last), .row_ready(row_ready), .abort(abort), .seed(seed),
        .seed_valid(seed_valid), .seed_ack(seed_ack), .frame_err(frame_err),
        .frames_loaded(frames_loaded)
    );

    gol_seed_loader #(.ROWS(8), .COLS(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .row_data(row_data), .row_valid(row_valid),
        .row_last(row_last), .row_ready(row_ready2), .abort(abort), .seed(seed2),
        .seed_valid(seed_valid2), .seed_ack(seed_ack), .frame_err(frame_err2),
        .frames_loaded(frames_loaded2)
    );

`ifdef SEED_NONZERO_CHECK_EN
    localparam bit NZ_CHECK = 1'b1;
`else
    localparam bit NZ_CHECK = 1'b0;
`endif

    // Frame-level reference model
    logic [7:0]  m_rows[$];
    bit          m_hold;
    logic [63:0] m_seed;
    int          m_cnt;
    bit          m_ferr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_rows.delete();
        m_hold = 1'b0;
        m_cnt  = 0;
        m_ferr = 1'b0;
        m_seed = '0;
    endtask

    task automatic model_step(input bit rv, input bit rl, input logic [7:0] rd,
                              input bit ab, input bit ack);
        int n;
        logic [63:0] s;
        m_ferr = 1'b0;
        if (ab) begin
            m_rows.delete();
            m_hold = 1'b0;
        end else if (!m_hold) begin
            if (rv) begin
                n = m_rows.size();
                if (rl != (n == 7)) begin
                    m_rows.delete();
                    m_ferr = 1'b1;
                end else begin
                    m_rows.push_back(rd);
                    if (n == 7) begin
                        s = '0;
                        for (int r = 0; r < 8; r++) s[r*8 +: 8] = m_rows[r];
                        m_rows.delete();
                        if (NZ_CHECK && s == 64'd0) begin
                            m_ferr = 1'b1;
                        end else begin
                            m_hold = 1'b1;
                            m_seed = s;
                        end
                    end
                end
            end
        end else if (ack) begin
            m_hold = 1'b0;
            m_cnt++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".row_ready"}, 64'(row_ready), 64'(!m_hold));
        chk({tag, ".seed_valid"}, 64'(seed_valid), 64'(m_hold));
        chk({tag, ".frame_err"}, 64'(frame_err), 64'(m_ferr));
        chk({tag, ".frames_loaded"}, 64'(frames_loaded), 64'(m_cnt % 65536));
        chk({tag, ".frames_loaded_w2"}, 64'(frames_loaded2), 64'(m_cnt % 4));
        if (m_hold) chk({tag, ".seed"}, seed, m_seed);
    endtask

    // One clock: drive, advance the model at the edge, compare 1 ns later
    task automatic cycle(input bit rv, input bit rl, input logic [7:0] rd,
                         input bit ab, input bit ack, input string tag);
        row_valid = rv; row_last = rl; row_data = rd; abort = ab; seed_ack = ack;
        @(posedge clk);
        model_step(rv, rl, rd, ab, ack);
        #1;
        check_model(tag);
        $display("txn %-8s rv=%0b rl=%0b rd=%h ab=%0b ack=%0b -> rdy=%0b vld=%0b ferr=%0b cnt=%0d seed=%h",
                 tag, rv, rl, rd, ab, ack, row_ready, seed_valid, frame_err, frames_loaded, seed);
    endtask

    task automatic send_frame(input logic [63:0] s, input string tag);
        for (int r = 0; r < 8; r++) cycle(1'b1, r == 7, s[r*8 +: 8], 1'b0, 1'b0, tag);
    endtask

    typedef struct {
        bit          rv, rl, ab, ack;
        logic [7:0]  rd;
        bit          e_ready, e_valid, e_ferr;
        int          e_cnt;
        logic [63:0] e_seed;
    } vec_t;

    vec_t tbl[13];

    initial begin
        logic [63:0] s;
        int          saved;
        logic [1:0]  c2;
        bit          rv, rl;

        // rows 0..7 of the glider-ish seed, beat 8 carries row_last
        for (int i = 0; i < 8; i++)
            tbl[i] = '{rv:1, rl:(i == 7), ab:0, ack:0, rd:(i == 4) ? 8'hE0 : 8'h00,
                       e_ready:(i != 7), e_valid:(i == 7), e_ferr:0, e_cnt:0,
                       e_seed:64'h0000_00E0_0000_0000};
        tbl[8]  = '{rv:0, rl:0, ab:0, ack:1, rd:8'h00, e_ready:1, e_valid:0, e_ferr:0, e_cnt:1, e_seed:64'h0};
        tbl[9]  = '{rv:1, rl:0, ab:0, ack:0, rd:8'h11, e_ready:1, e_valid:0, e_ferr:0, e_cnt:1, e_seed:64'h0};
        tbl[10] = '{rv:1, rl:0, ab:0, ack:0, rd:8'h22, e_ready:1, e_valid:0, e_ferr:0, e_cnt:1, e_seed:64'h0};
        tbl[11] = '{rv:1, rl:1, ab:0, ack:0, rd:8'h33, e_ready:1, e_valid:0, e_ferr:1, e_cnt:1, e_seed:64'h0};
        tbl[12] = '{rv:0, rl:0, ab:0, ack:0, rd:8'h00, e_ready:1, e_valid:0, e_ferr:0, e_cnt:1, e_seed:64'h0};

        reset = 1'b1; row_valid = 0; row_last = 0; row_data = 0; abort = 0; seed_ack = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("reset.row_ready", 64'(row_ready), 64'd1);
        chk("reset.seed_valid", 64'(seed_valid), 64'd0);
        chk("reset.frame_err", 64'(frame_err), 64'd0);
        chk("reset.frames_loaded", 64'(frames_loaded), 64'd0);
        chk("reset.seed", seed, 64'd0);

        // Vector table
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].rv, tbl[i].rl, tbl[i].rd, tbl[i].ab, tbl[i].ack, "table");
            chk($sformatf("tbl%0d.row_ready", i), 64'(row_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d.seed_valid", i), 64'(seed_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d.frame_err", i), 64'(frame_err), 64'(tbl[i].e_ferr));
            chk($sformatf("tbl%0d.frames_loaded", i), 64'(frames_loaded), 64'(tbl[i].e_cnt));
            if (tbl[i].e_valid) chk($sformatf("tbl%0d.seed", i), seed, tbl[i].e_seed);
        end

        // Clean all-ones frame
        send_frame(64'hFFFF_FFFF_FFFF_FFFF, "ones");
        chk("ones.seed", seed, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("ones.valid", 64'(seed_valid), 64'd1);
        cycle(0, 0, 8'h00, 0, 1, "ones");

        // Beat 8 without row_last: dropped, next beat becomes row 0
        for (int r = 0; r < 8; r++) cycle(1, 0, 8'(r + 1), 0, 0, "nolast");
        chk("nolast.frame_err", 64'(frame_err), 64'd1);
        chk("nolast.valid", 64'(seed_valid), 64'd0);
        send_frame(64'hA7A6_A5A4_A3A2_A1A0, "nolast");
        chk("nolast.seed", seed, 64'hA7A6_A5A4_A3A2_A1A0);
        cycle(0, 0, 8'h00, 0, 1, "nolast");

        // Abort after five rows, then a clean frame
        for (int r = 0; r < 5; r++) cycle(1, 0, 8'h55, 0, 0, "abort");
        cycle(0, 0, 8'h00, 1, 0, "abort");
        chk("abort.frame_err", 64'(frame_err), 64'd0);
        send_frame(64'h0101_0101_0101_0101, "abort");
        chk("abort.seed", seed, 64'h0101_0101_0101_0101);
        saved = frames_loaded;
        cycle(0, 0, 8'h00, 1, 1, "abortack");
        chk("abortack.frames_loaded", 64'(frames_loaded), 64'(saved));
        chk("abortack.valid", 64'(seed_valid), 64'd0);

        // Seed held stable in HOLD while upstream keeps row_valid high
        for (int f = 0; f < 3; f++) begin
            s = {$urandom, $urandom} | 64'h1;
            send_frame(s, "hold");
            for (int k = 0; k < 10; k++) begin
                cycle(1, k[0], 8'($urandom), 0, 0, "hold");
                chk("hold.seed", seed, s);
                chk("hold.row_ready", 64'(row_ready), 64'd0);
            end
            cycle(0, 0, 8'h00, 0, 1, "hold");
        end

        // Four accepted frames return the 2-bit counter to its start value
        c2 = frames_loaded2;
        for (int f = 0; f < 4; f++) begin
            send_frame({32'hC0DE_0000, 32'(f + 1)}, "wrap");
            cycle(0, 0, 8'h00, 0, 1, "wrap");
        end
        chk("wrap.frames_loaded_w2", 64'(frames_loaded2), 64'(c2));

        // All-zero board
        send_frame(64'd0, "zero");
        chk("zero.valid", 64'(seed_valid), NZ_CHECK ? 64'd0 : 64'd1);
        chk("zero.frame_err", 64'(frame_err), NZ_CHECK ? 64'd1 : 64'd0);
        if (!NZ_CHECK) chk("zero.seed", seed, 64'd0);
        cycle(0, 0, 8'h00, 0, 1, "zero");

        // Asynchronous reset while holding a seed
        send_frame(64'h1234_5678_9ABC_DEF0, "areset");
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk("areset.row_ready", 64'(row_ready), 64'd1);
        chk("areset.seed_valid", 64'(seed_valid), 64'd0);
        chk("areset.frames_loaded", 64'(frames_loaded), 64'd0);
        chk("areset.seed", seed, 64'd0);
        @(posedge clk);
        #2 reset = 1'b0;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            if (m_rows.size() == 7) rl = ($urandom_range(0, 7) != 0);
            else                    rl = ($urandom_range(0, 15) == 0);
            cycle(rv, rl, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
